// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and widths used by the memory port arbiter
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    IF_DROP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - unified memory port request/acknowledge bundle
interface mem_port_arbiter_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  // Arbiter side: issues the request, receives the acknowledge and read data.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  // Memory side.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cancel,
  input  logic                if_req,
  input  logic [XLEN-1:0]     if_addr,
  output logic                if_done,
  output logic [XLEN-1:0]     if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [XLEN-1:0]     dm_addr,
  input  logic [XLEN-1:0]     dm_wdata,
  input  logic [STRB_W-1:0]   dm_wstrb,
  output logic                dm_done,
  output logic [XLEN-1:0]     dm_rdata,
  mem_port_arbiter_if.master  mem
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

  arb_state_t state;
  arb_state_t state_nxt;
  logic [3:0] streak;
  logic       if_want;
  logic       grant_dm;
  logic       grant_if;
  logic       if_capture;
  logic       dm_capture;
  logic       req_clear;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Arbitration, completion decode and next state; a killed fetch still waits for its ack.
  always_comb begin
    state_nxt  = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    if_capture = 1'b0;
    dm_capture = 1'b0;
    req_clear  = 1'b0;
    if_want    = if_req & ~cancel;
    case (state)
      IDLE: begin
        if (dm_req && !(if_want && streak == STREAK_MAX)) begin
          grant_dm  = 1'b1;
          state_nxt = DM_BUSY;
        end else if (if_want) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (mem.mem_ack) begin
          req_clear  = 1'b1;
          if_capture = ~cancel;
          state_nxt  = IDLE;
        end else if (cancel) begin
          state_nxt  = IF_DROP;
        end
      end
      IF_DROP: begin
        if (mem.mem_ack) begin
          req_clear = 1'b1;
          state_nxt = IDLE;
        end
      end
      DM_BUSY: begin
        if (mem.mem_ack) begin
          req_clear  = 1'b1;
          dm_capture = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Consecutive data-side grants while a fetch is waiting, saturating at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak <= 4'd0;
    end else if (!if_req || grant_if) begin
      streak <= 4'd0;
    end else if (grant_dm && streak < STREAK_MAX) begin
      streak <= streak + 4'd1;
    end
  end

  // Memory-side request fields, loaded on grant and held until the ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
    end else if (grant_dm) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= dm_we;
      mem.mem_addr  <= dm_addr;
      mem.mem_wdata <= dm_wdata;
      mem.mem_wstrb <= dm_we ? dm_wstrb : '0;
    end else if (grant_if) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= if_addr;
      mem.mem_wdata <= '0;
      mem.mem_wstrb <= '0;
    end else if (req_clear) begin
      mem.mem_req   <= 1'b0;
    end
  end

  // Completion pulses and read data returned to the pipeline; rdata holds between captures.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= if_capture;
      dm_done <= dm_capture;
      if (if_capture) if_rdata <= mem.mem_rdata;
      if (dm_capture && !mem.mem_we) dm_rdata <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAX     = 4;
  localparam int M_FREE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DATA  = 2;
  localparam int M_DROP  = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cancel = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic        dm_done;
  logic [31:0] dm_rdata;

  mem_port_arbiter_if mem();

  mem_port_arbiter #(.MAX_MEM_STREAK(MAX)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cancel   (cancel),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wstrb (dm_wstrb),
    .dm_done  (dm_done),
    .dm_rdata (dm_rdata),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the port, the access it carries, and what the pipeline sees.
  int          m_owner;
  int          m_streak;
  logic        m_req, m_we, m_if_done, m_dm_done;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic [3:0]  m_wstrb;

  // Memory responder controls.
  int          mem_cnt = 0;
  int          mem_lat = 1;
  bit          rand_mode = 1'b0;
  bit          stray_en = 1'b0;
  logic [31:0] fixed_rdata = '0;

  int          t_req, t_done, n_done, n_hi, ng;
  bit          got, prev;
  logic [9:0]  pattern;

  task automatic check(input string tag, input logic [135:0] got_v, input logic [135:0] exp_v);
    n_checks++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
  endtask

  function automatic logic [135:0] dut_vec();
    return {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, mem.mem_wstrb,
            if_done, if_rdata, dm_done, dm_rdata};
  endfunction

  function automatic logic [135:0] model_vec();
    return {m_req, m_we, m_addr, m_wdata, m_wstrb, m_if_done, m_if_rdata, m_dm_done, m_dm_rdata};
  endfunction

  task automatic model_reset();
    m_owner = M_FREE; m_streak = 0;
    m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    m_if_done = 0; m_dm_done = 0; m_if_rdata = 0; m_dm_rdata = 0;
  endtask

  // Applies the port-sharing rules to the inputs that were present at the edge just taken.
  task automatic model_step();
    bit want_if, take_dm, take_if;
    want_if = if_req && !cancel;
    take_dm = 0;
    take_if = 0;
    m_if_done = 0;
    m_dm_done = 0;
    if (m_owner == M_FREE) begin
      if (dm_req && !(want_if && m_streak == MAX)) take_dm = 1;
      else if (want_if) take_if = 1;
      if (take_dm) begin
        m_owner = M_DATA; m_req = 1; m_we = dm_we; m_addr = dm_addr;
        m_wdata = dm_wdata; m_wstrb = dm_we ? dm_wstrb : 4'h0;
      end
      if (take_if) begin
        m_owner = M_FETCH; m_req = 1; m_we = 0; m_addr = if_addr; m_wdata = 0; m_wstrb = 0;
      end
    end else if (mem.mem_ack) begin
      if (m_owner == M_FETCH && !cancel) begin
        m_if_done = 1; m_if_rdata = mem.mem_rdata;
      end
      if (m_owner == M_DATA) begin
        m_dm_done = 1;
        if (!m_we) m_dm_rdata = mem.mem_rdata;
      end
      m_owner = M_FREE;
      m_req = 0;
    end else if (m_owner == M_FETCH && cancel) begin
      m_owner = M_DROP;
    end
    if (!if_req || take_if) m_streak = 0;
    else if (take_dm && m_streak < MAX) m_streak++;
  endtask

  // Memory responder: acks in the mem_lat-th cycle of a request, optional stray acks.
  task automatic mem_agent();
    mem.mem_ack = 0;
    if (rand_mode) mem.mem_rdata = $urandom;
    if (mem.mem_req) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem.mem_ack = 1;
        if (!rand_mode) mem.mem_rdata = fixed_rdata;
        mem_cnt = 0;
        if (rand_mode) mem_lat = $urandom_range(1, 3);
      end
    end else begin
      mem_cnt = 0;
      if (stray_en && $urandom_range(0, 15) == 0) mem.mem_ack = 1;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (!resetn) model_reset();
    else model_step();
    check(tag, dut_vec(), model_vec());
    mem_agent();
  endtask

  task automatic idle(input int n);
    if_req = 0; dm_req = 0; cancel = 0;
    repeat (n) tick("idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    mem.mem_ack = 0;
    mem.mem_rdata = 0;

    tick("reset");
    tick("reset");
    check("reset_state", dut_vec(), '0);
    resetn = 1;
    idle(2);

    // Lone fetch, memory acks in the second cycle of mem_req.
    rand_mode = 0; mem_lat = 2; fixed_rdata = 32'h2402_0001;
    if_addr = 32'h100; if_req = 1;
    got = 0; t_req = 0; t_done = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      tick("lone");
      if (mem.mem_req && t_req == 0) begin
        t_req = i;
        check("lone_addr", mem.mem_addr, 32'h100);
        check("lone_wstrb", mem.mem_wstrb, 4'h0);
      end
      if (if_done) begin
        got = 1; t_done = i;
        check("lone_rdata", if_rdata, 32'h2402_0001);
        if_req = 0;
      end
    end
    check("lone_req_cycle", t_req, 1);
    check("lone_done_cycle", t_done, 3);
    idle(3);

    // Conflict: store wins, fetch follows the cycle after dm_done.
    mem_lat = 1;
    if_addr = 32'h200; if_req = 1;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    tick("conf");
    check("conf_dm_first", {mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, mem.mem_wstrb},
          {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF});
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick("conf");
      if (dm_done) begin got = 1; dm_req = 0; end
    end
    check("conf_dm_done", got, 1);
    tick("conf");
    check("conf_if_next", {mem.mem_req, mem.mem_we, mem.mem_addr}, {1'b1, 1'b0, 32'h200});
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick("conf");
      if (if_done) begin got = 1; if_req = 0; end
    end
    check("conf_if_done", got, 1);
    idle(3);

    // Starvation: loads held back to back while a fetch waits.
    mem_lat = 1;
    if_addr = 32'h300; if_req = 1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
    pattern = '0; ng = 0; prev = 0;
    for (int i = 0; i < 80 && ng < 10; i++) begin
      tick("starve");
      if (mem.mem_req && !prev) begin
        pattern[ng] = (mem.mem_addr == 32'h300);
        ng++;
      end
      prev = mem.mem_req;
      if (dm_done) dm_addr = dm_addr + 32'd4;
    end
    check("starve_grants", ng, 10);
    check("starve_pattern", pattern, 10'b10000_10000);
    idle(6);

    // Cancel one cycle after the fetch grant, ack three cycles later.
    mem_lat = 4;
    if_addr = 32'h500; if_req = 1;
    tick("cxl");
    cancel = 1; if_req = 0;
    n_done = 0; n_hi = mem.mem_req ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick("cxl");
      cancel = 0;
      if (if_done) n_done++;
      if (mem.mem_req) n_hi++;
    end
    check("cxl_no_done", n_done, 0);
    check("cxl_req_held", n_hi, 4);
    idle(2);

    // Cancel in the same cycle as the ack.
    mem_lat = 1;
    if_addr = 32'h600; if_req = 1;
    tick("cxl_ack");
    cancel = 1; if_req = 0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick("cxl_ack");
      cancel = 0;
      if (if_done) n_done++;
    end
    check("cxl_ack_no_done", n_done, 0);

    // Cancel while a load is in flight: completion still reported.
    mem_lat = 3; fixed_rdata = 32'h1234_5678;
    dm_req = 1; dm_we = 0; dm_addr = 32'h700;
    tick("cxl_dm");
    cancel = 1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick("cxl_dm");
      cancel = 0;
      if (dm_done) begin
        got = 1; dm_req = 0;
        check("cxl_dm_rdata", dm_rdata, 32'h1234_5678);
      end
    end
    check("cxl_dm_done", got, 1);
    idle(2);

    // Asynchronous reset while a store is waiting for its ack.
    mem_lat = 5;
    dm_req = 1; dm_we = 1; dm_addr = 32'h800; dm_wdata = 32'h5555_AAAA; dm_wstrb = 4'h3;
    tick("rst");
    tick("rst");
    check("rst_busy", mem.mem_req, 1'b1);
    #2;
    resetn = 0;
    #1;
    model_reset();
    mem.mem_ack = 0; mem_cnt = 0;
    check("async_reset", dut_vec(), '0);
    dm_req = 0;
    n_done = 0;
    repeat (2) begin
      tick("rst");
      if (dm_done) n_done++;
    end
    resetn = 1;
    repeat (6) begin
      tick("rst");
      if (dm_done) n_done++;
    end
    check("rst_no_done", n_done, 0);

    // Randomized traffic against the model, stray acks included.
    rand_mode = 1; stray_en = 1; mem_lat = 2;
    for (int c = 0; c < 4000; c++) begin
      tick("rand");
      if (dm_req && dm_done) dm_req = 0;
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom;
        dm_wdata = $urandom; dm_wstrb = 4'($urandom_range(0, 15));
      end
      if (if_req && (if_done || cancel)) if_req = 0;
      if (!if_req && $urandom_range(0, 1) == 0) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      cancel = ($urandom_range(0, 11) == 0);
    end
    stray_en = 0;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
